// File: rtl/lfsr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_seq_ctrl
// Sequencing controller for the 16-bit XNOR LFSR (taps 16,15,13,4, seed
// 16'h0145, registered max_tick). An accepted start restarts the LFSR through
// a one-cycle o_lfsr_clr pulse. The controller then paces o_sh_en once every
// DIV clocks. A run is either a burst of i_len shifts or a full period that
// ends on i_lfsr_max_tick. During the run it counts the ones and zeros of the
// serial bit (lfsr_q[15], sampled before the shift) and the number of shifts.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_start             begin a run (sampled only in IDLE)
//   i_mode              0 = burst of i_len shifts, 1 = run until max_tick
//   i_len[15:0]         burst length, latched on an accepted start
//   i_abort             terminate an active run
//   i_lfsr_q[15:0]      LFSR current state
//   i_lfsr_max_tick     LFSR returned-to-seed flag
//   o_lfsr_clr          registered one-cycle restart pulse to the LFSR
//   o_sh_en             LFSR shift enable (combinational)
//   o_busy              high in INIT and RUN
//   o_done              one-cycle pulse in DONE
//   o_ones_cnt/o_zeros_cnt  serial-bit statistics of the last run
//   o_shift_cnt[16:0]   shifts issued in the last run
//   o_aborted/o_timeout how the last run ended
//   o_lockup            (LFSR_CTRL_LOCKUP_DET_EN only) run ended on 16'hFFFF
//
// Optional feature macro: LFSR_CTRL_LOCKUP_DET_EN
// ---------------------------------------------------------------------------
module lfsr_seq_ctrl #(
    parameter int unsigned DIV     = 1,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic        i_mode,
    input  logic [15:0] i_len,
    input  logic        i_abort,
    input  logic [15:0] i_lfsr_q,
    input  logic        i_lfsr_max_tick,
    output logic        o_lfsr_clr,
    output logic        o_sh_en,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_ones_cnt,
    output logic [15:0] o_zeros_cnt,
    output logic [16:0] o_shift_cnt,
    output logic        o_aborted,
`ifdef LFSR_CTRL_LOCKUP_DET_EN
    output logic        o_lockup,
`endif
    output logic        o_timeout
);

    localparam int unsigned   PW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PACE_LAST  = PW'(DIV - 1);
    localparam logic [16:0]   SHIFT_LAST = 17'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_mode;
    logic [15:0]   r_len;
    logic [PW-1:0] r_pace;
    logic [15:0]   r_ones_cnt;
    logic [15:0]   r_zeros_cnt;
    logic [16:0]   r_shift_cnt;
    logic          r_aborted;
    logic          r_timeout;
    logic          r_lfsr_clr;
    logic          r_busy;
    logic          r_done;

    logic          w_in_run;
    logic          w_tick;
    logic          w_period_end;
    logic          w_lockup_hit;
    logic          w_sh_en;
    logic          w_burst_end;
    logic          w_timeout_hit;
    logic          w_end_run;
    logic          w_burst_zero;

`ifdef LFSR_CTRL_LOCKUP_DET_EN
    logic          r_lockup;
    // All-ones is the XNOR lockup state: the LFSR would never leave it.
    assign w_lockup_hit = (i_lfsr_q == 16'hFFFF);
    assign o_lockup     = r_lockup;
`else
    logic          w_unused;
    assign w_lockup_hit = 1'b0;
    assign w_unused     = ^i_lfsr_q[14:0];
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a zero-length burst skips INIT/RUN entirely.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = w_burst_zero ? S_DONE : S_INIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_INIT:  w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_end_run) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Run control: shift enable and exit conditions in priority order
    // abort > lockup > max_tick > burst end > timeout. The higher-priority
    // exits suppress the shift in that cycle.
    always_comb begin
        w_burst_zero  = ~i_mode & (i_len == 16'd0);
        w_in_run      = (r_state == S_RUN);
        w_tick        = (r_pace == PACE_LAST);
        w_period_end  = r_mode & i_lfsr_max_tick;
        w_sh_en       = w_in_run & w_tick & ~i_abort & ~w_lockup_hit & ~w_period_end;
        w_burst_end   = w_sh_en & ~r_mode & ((r_shift_cnt + 17'd1) == {1'b0, r_len});
        w_timeout_hit = w_sh_en & r_mode & (r_shift_cnt == SHIFT_LAST);
        w_end_run     = w_in_run & (i_abort | w_lockup_hit | w_period_end
                                    | w_burst_end | w_timeout_hit);
    end

    // Datapath and registered status outputs. Results are cleared when a
    // start is accepted, so they already read zero during INIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode      <= 1'b0;
            r_len       <= 16'd0;
            r_pace      <= '0;
            r_ones_cnt  <= 16'd0;
            r_zeros_cnt <= 16'd0;
            r_shift_cnt <= 17'd0;
            r_aborted   <= 1'b0;
            r_timeout   <= 1'b0;
            r_lfsr_clr  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef LFSR_CTRL_LOCKUP_DET_EN
            r_lockup    <= 1'b0;
`endif
        end else begin
            r_lfsr_clr <= (w_state_nxt == S_INIT);
            r_busy     <= (w_state_nxt == S_INIT) || (w_state_nxt == S_RUN);
            r_done     <= (w_state_nxt == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_mode      <= i_mode;
                        r_len       <= i_len;
                        r_pace      <= '0;
                        r_ones_cnt  <= 16'd0;
                        r_zeros_cnt <= 16'd0;
                        r_shift_cnt <= 17'd0;
                        r_aborted   <= 1'b0;
                        r_timeout   <= 1'b0;
`ifdef LFSR_CTRL_LOCKUP_DET_EN
                        r_lockup    <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    r_pace <= w_tick ? '0 : r_pace + 1'b1;
                    if (w_sh_en) begin
                        r_shift_cnt <= r_shift_cnt + 17'd1;
                        if (i_lfsr_q[15]) begin
                            r_ones_cnt <= r_ones_cnt + 16'd1;
                        end else begin
                            r_zeros_cnt <= r_zeros_cnt + 16'd1;
                        end
                    end
                    if (i_abort) begin
                        r_aborted <= 1'b1;
                    end
`ifdef LFSR_CTRL_LOCKUP_DET_EN
                    if (!i_abort && w_lockup_hit) begin
                        r_lockup <= 1'b1;
                    end
`endif
                    if (w_timeout_hit) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_lfsr_clr  = r_lfsr_clr;
    assign o_sh_en     = w_sh_en;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_ones_cnt  = r_ones_cnt;
    assign o_zeros_cnt = r_zeros_cnt;
    assign o_shift_cnt = r_shift_cnt;
    assign o_aborted   = r_aborted;
    assign o_timeout   = r_timeout;

endmodule
